// File: rtl/tlul_copy_master.sv
// TL-UL initiator that copies a block of 64-bit words using one Get and one
// PutFullData per word, with exactly one transaction in flight at any time.
module tlul_copy_master #(
  parameter int TL_AW     = 32,
  parameter int TL_DW     = 64,
  parameter int TL_AIW    = 8,
  parameter int TL_SZW    = 3,
  parameter int TL_DIW    = 1,
  parameter int TL_DBW    = TL_DW / 8,
  parameter int SOURCE_ID = 0,
  parameter int LEN_W     = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [TL_AW-1:0]  src_addr_i,
  input  logic [TL_AW-1:0]  dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [2:0]        master_a_opcode,
  output logic [2:0]        master_a_param,
  output logic [TL_SZW-1:0] master_a_size,
  output logic [TL_AIW-1:0] master_a_source,
  output logic [TL_AW-1:0]  master_a_address,
  output logic [TL_DBW-1:0] master_a_mask,
  output logic [TL_DW-1:0]  master_a_data,
  output logic              master_a_corrupt,
  output logic              master_a_valid,
  input  logic              master_a_ready,
  input  logic [2:0]        master_d_opcode,
  input  logic [1:0]        master_d_param,
  input  logic [TL_SZW-1:0] master_d_size,
  input  logic [TL_DIW-1:0] master_d_sink,
  input  logic [TL_AIW-1:0] master_d_source,
  input  logic              master_d_denied,
  input  logic [TL_DW-1:0]  master_d_data,
  input  logic              master_d_corrupt,
  input  logic              master_d_valid,
  output logic              master_d_ready
);

  localparam logic [TL_AIW-1:0] SRC_ID     = TL_AIW'(SOURCE_ID);
  localparam int                TMR_W      = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [TL_AW-1:0]  WORD_BYTES = TL_AW'(8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_RSP = 3'd2,
    WR_REQ = 3'd3,
    WR_RSP = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TL_AW-1:0]   src_q, src_d;
  logic [TL_AW-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TL_DW-1:0]   wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               rd_ok, wr_ok;

  // Response fields the copy does not depend on.
  logic unused_d_fields;
  assign unused_d_fields = ^{master_d_param, master_d_size, master_d_sink};

  assign rd_ok = (master_d_opcode == 3'h1) && (master_d_source == SRC_ID) &&
                 !master_d_denied && !master_d_corrupt;
  assign wr_ok = (master_d_opcode == 3'h0) && (master_d_source == SRC_ID) &&
                 !master_d_denied;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    cnt_d          = cnt_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    timer_d        = timer_q;
    master_a_valid = 1'b0;
    master_d_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d = src_addr_i;
          dst_d = dst_addr_i;
          cnt_d = len_i;
          err_d = 1'b0;
          if ((src_addr_i[2:0] != 3'd0) || (dst_addr_i[2:0] != 3'd0)) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else if (len_i == '0) begin
            state_d = FINISH;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        master_a_valid = 1'b1;
        if (master_a_ready) begin
          state_d = RD_RSP;
          timer_d = '0;
        end
      end
      RD_RSP: begin
        master_d_ready = 1'b1;
        if (master_d_valid) begin
          wdata_d = master_d_data;
          if (rd_ok) begin
            state_d = WR_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WR_REQ: begin
        master_a_valid = 1'b1;
        if (master_a_ready) begin
          state_d = WR_RSP;
          timer_d = '0;
        end
      end
      WR_RSP: begin
        master_d_ready = 1'b1;
        if (master_d_valid) begin
          if (wr_ok) begin
            // Addresses wrap silently at the top of the address space.
            src_d   = src_q + WORD_BYTES;
            dst_d   = dst_q + WORD_BYTES;
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? FINISH : RD_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A-channel fields are pure functions of held registers, so they stay
  // stable for as long as a request waits on a_ready.
  assign master_a_opcode  = (state_q == WR_REQ) ? 3'h0 : 3'h4;
  assign master_a_param   = 3'h0;
  assign master_a_size    = TL_SZW'(3);
  assign master_a_source  = SRC_ID;
  assign master_a_address = (state_q == WR_REQ) ? dst_q : src_q;
  assign master_a_mask    = '1;
  assign master_a_data    = (state_q == WR_REQ) ? wdata_q : '0;
  assign master_a_corrupt = 1'b0;

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == FINISH);
  assign error_o = err_q;

endmodule

// File: tb/tb_tlul_copy_master.sv
// Randomized bench for tlul_copy_master: a TL-UL responder model, a
// word-level reference of the copy, and a scoreboard monitor on A and done.
module tb_tlul_copy_master;

  localparam int         TO  = 16;
  localparam logic [7:0] SID = 8'd0;
  localparam int F_NONE = 0, F_DENY = 1, F_CORRUPT = 2, F_BADOP = 3, F_BADSRC = 4, F_SILENT = 5;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [63:0] data;
  } areq_t;

  typedef struct packed {
    logic err;
    logic tmo;
    logic imm;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy_o, done_o, error_o;
  logic [2:0]  a_opcode, a_param;
  logic [2:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt, a_valid, a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [0:0]  d_sink;
  logic [7:0]  d_source;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt, d_valid, d_ready;

  int n_pass = 0, n_total = 0;
  int cyc = 0, last_hs = 0, start_cyc = 0, n_hs = 0, done_cnt = 0;
  areq_t exp_a[$];
  done_t exp_d[$];
  logic [63:0] mem [logic [31:0]];

  // Responder configuration for the current copy.
  int f_kind = F_NONE, f_idx = 0, st_idx = -1, st_len = 0, req_idx = 0, resp_idx = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tlul_copy_master #(.SOURCE_ID(0), .LEN_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .src_addr_i(src_addr), .dst_addr_i(dst_addr), .len_i(len),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .master_a_opcode(a_opcode), .master_a_param(a_param), .master_a_size(a_size),
    .master_a_source(a_source), .master_a_address(a_address), .master_a_mask(a_mask),
    .master_a_data(a_data), .master_a_corrupt(a_corrupt), .master_a_valid(a_valid),
    .master_a_ready(a_ready),
    .master_d_opcode(d_opcode), .master_d_param(d_param), .master_d_size(d_size),
    .master_d_sink(d_sink), .master_d_source(d_source), .master_d_denied(d_denied),
    .master_d_data(d_data), .master_d_corrupt(d_corrupt), .master_d_valid(d_valid),
    .master_d_ready(d_ready)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic logic [63:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a ^ 32'hA5A5_0F0F, ~a};
  endfunction

  // Reference: word-level walk of the copy, stopping at the first faulted response.
  task automatic model_push(input logic [31:0] src, dst, input int n, input int fk, fi);
    done_t d;
    logic [31:0] ra, wa;
    d = '0;
    if (src[2:0] != 3'd0 || dst[2:0] != 3'd0) begin
      d.err = 1'b1;
      d.imm = 1'b1;
    end else if (n == 0) begin
      d.imm = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        ra = src + 32'(i * 8);
        wa = dst + 32'(i * 8);
        exp_a.push_back('{3'h4, ra, 64'h0});
        if (fk != F_NONE && fi == 2 * i) begin
          d.err = 1'b1;
          d.tmo = (fk == F_SILENT);
          break;
        end
        exp_a.push_back('{3'h0, wa, rd_word(ra)});
        if (fk != F_NONE && fk != F_CORRUPT && fi == 2 * i + 1) begin
          d.err = 1'b1;
          d.tmo = (fk == F_SILENT);
          break;
        end
      end
    end
    exp_d.push_back(d);
  endtask

  task automatic pulse_start(input logic [31:0] src, dst, input int n);
    @(posedge clk); #1;
    src_addr = src; dst_addr = dst; len = 16'(n); start_i = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_copy(input logic [31:0] src, dst, input int n, input int fk, fi, si, sl,
                          input bit mid_start);
    int d0;
    int k;
    f_kind = fk; f_idx = fi; st_idx = si; st_len = sl; req_idx = 0; resp_idx = 0;
    model_push(src, dst, n, fk, fi);
    d0 = done_cnt;
    pulse_start(src, dst, n);
    if (mid_start) begin
      repeat (3) @(posedge clk);
      #1;
      src_addr = 32'h5000; dst_addr = 32'h6000; len = 16'd1; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == d0) begin
      n_total++;
      $display("FAIL done_wait: got no done_o within 3000 cycles, required a done pulse");
    end
    @(negedge clk);
    chk("idle_after_done", 128'({busy_o, done_o, a_valid}), 128'(0));
    $display("copy src=%h dst=%h len=%0d fault=%0d@%0d -> error_o=%0b", src, dst, n, fk, fi, error_o);
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_mid_copy();
    int k;
    int base;
    f_kind = F_NONE; st_idx = -1; req_idx = 0; resp_idx = 0;
    model_push(32'h0002_0000, 32'h8002_0000, 8, F_NONE, 0);
    base = n_hs;
    pulse_start(32'h0002_0000, 32'h8002_0000, 8);
    k = 0;
    while (n_hs < base + 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("hs_before_reset", 128'(n_hs >= base + 3), 128'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_mid_copy", 128'({busy_o, done_o, error_o, a_valid, d_ready}), 128'(0));
    $display("copy src=00020000 dst=80020000 len=8 reset after %0d requests", n_hs - base);
    exp_a.delete();
    exp_d.delete();
    repeat (3) @(posedge clk);
    chk("quiet_after_reset", 128'({busy_o, a_valid}), 128'(0));
  endtask

  task automatic random_copies(input int count);
    logic [31:0] s, d;
    int n, r, fk, fi;
    for (int t = 0; t < count; t++) begin
      s = 32'h0001_0000 + ($urandom & 32'h0000_FFF8);
      d = 32'h8000_0000 + ($urandom & 32'h0000_FFF8);
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 11) == 0) s = s | 32'h4;
      r = $urandom_range(0, 9);
      fk = (r <= 5) ? F_NONE : (r == 6) ? F_DENY : (r == 7) ? F_CORRUPT :
           (r == 8) ? (($urandom_range(0, 1) == 0) ? F_BADOP : F_BADSRC) : F_SILENT;
      fi = $urandom_range(0, 2 * n - 1);
      run_copy(s, d, n, fk, fi, -1, 0, 1'b0);
    end
  endtask

  // Responder: accepts A with optional stalls, answers D after a short delay.
  initial begin : responder
    int phase, stall, dly;
    bit armed;
    logic [2:0]  rq_op;
    logic [31:0] rq_addr;
    logic [2:0]  r_op;
    logic [63:0] r_data;
    logic [7:0]  r_src;
    logic        r_den, r_cor;
    phase = 0; stall = 0; dly = 0; armed = 1'b0;
    rq_op = '0; rq_addr = '0; r_op = '0; r_data = '0; r_src = '0; r_den = 1'b0; r_cor = 1'b0;
    a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = 3'd3;
    d_sink = '0; d_source = '0; d_denied = 1'b0; d_data = '0; d_corrupt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_ready = 1'b0; d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
        phase = 0; armed = 1'b0;
      end else begin
        if (phase == 3) begin
          d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
          d_data = {$urandom, $urandom};
          phase = 0;
        end
        if (phase == 1) begin
          a_ready = 1'b0;
          r_op = (rq_op == 3'h4) ? 3'h1 : 3'h0;
          r_data = (rq_op == 3'h4) ? rd_word(rq_addr) : 64'h0;
          r_src = SID; r_den = 1'b0; r_cor = 1'b0;
          phase = 2;
          dly = $urandom_range(0, 3);
          if (f_kind != F_NONE && resp_idx == f_idx) begin
            case (f_kind)
              F_DENY:    r_den = 1'b1;
              F_CORRUPT: r_cor = 1'b1;
              F_BADOP:   r_op = (rq_op == 3'h4) ? 3'h0 : 3'h1;
              F_BADSRC:  r_src = SID + 8'd1;
              default:   phase = 4;
            endcase
          end
          resp_idx++;
        end
        if (phase == 2) begin
          if (dly > 0) dly--;
          else begin
            d_opcode = r_op; d_source = r_src; d_denied = r_den; d_corrupt = r_cor;
            d_data = r_data; d_valid = 1'b1;
            phase = 3;
          end
        end
        if (phase == 4 && !busy_o) phase = 0;
        if (phase == 0) begin
          if (!a_valid) begin
            a_ready = 1'b0;
            armed = 1'b0;
          end else begin
            if (!armed) begin
              armed = 1'b1;
              stall = (req_idx == st_idx) ? st_len :
                      (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            if (stall > 0) begin
              stall--;
              a_ready = 1'b0;
            end else begin
              a_ready = 1'b1;
              rq_op = a_opcode; rq_addr = a_address;
              armed = 1'b0;
              req_idx++;
              phase = 1;
            end
          end
        end
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  initial begin : monitor
    bit stall_prev;
    done_t dd;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("a_valid_held", 128'(a_valid), 128'(1));
        if (a_valid) begin
          chk("d_ready_low_in_req", 128'(d_ready), 128'(0));
          if (exp_a.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_a_req: got op=%h addr=%h, required no request", a_opcode, a_address);
          end else begin
            chk("a_fields", 128'({a_opcode, a_address, a_data}), 128'(exp_a[0]));
          end
          if (a_ready) begin
            chk("a_const_fields", 128'({a_param, a_size, a_source, a_mask, a_corrupt}),
                128'({3'd0, 3'd3, SID, 8'hFF, 1'b0}));
            if (exp_a.size() != 0) void'(exp_a.pop_front());
            last_hs = cyc;
            n_hs++;
          end
        end
        stall_prev = a_valid && !a_ready;
        if (done_o) begin
          done_cnt++;
          if (exp_d.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got done_o=1, required no completion pending");
          end else begin
            dd = exp_d.pop_front();
            chk("error_o", 128'(error_o), 128'(dd.err));
            chk("requests_remaining", 128'(exp_a.size()), 128'(0));
            // The handshake is sampled half a cycle before its edge, so the
            // FINISH cycle lands TIMEOUT edges later at a count of TO+1.
            if (dd.tmo) chk("timeout_latency", 128'(cyc - last_hs), 128'(TO + 1));
            if (dd.imm) chk("done_latency", 128'(cyc - start_cyc), 128'(1));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; start_i = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 128'({busy_o, done_o, error_o, a_valid, d_ready}), 128'(0));

    mem[32'h1000] = 64'h11; mem[32'h1008] = 64'h22;
    mem[32'h1010] = 64'h33; mem[32'h1018] = 64'h44;
    run_copy(32'h1000, 32'h2000, 4, F_NONE, 0, -1, 0, 1'b0);
    chk("basic_no_error", 128'(error_o), 128'(0));
    run_copy(32'h1000, 32'h3000, 2, F_NONE, 0, 0, 5, 1'b0);
    run_copy(32'h1000, 32'h4000, 4, F_DENY, 2, -1, 0, 1'b0);
    run_copy(32'h1004, 32'h2000, 3, F_NONE, 0, -1, 0, 1'b0);
    run_copy(32'h1000, 32'h2000, 2, F_SILENT, 0, -1, 0, 1'b0);
    run_copy(32'h1000, 32'h2000, 0, F_NONE, 0, -1, 0, 1'b0);
    chk("len0_clears_error", 128'(error_o), 128'(0));
    run_copy(32'h1000, 32'h7000, 4, F_NONE, 0, -1, 0, 1'b1);
    run_copy(32'hFFFF_FFF0, 32'h8000_1000, 4, F_NONE, 0, -1, 0, 1'b0);
    run_copy(32'h1000, 32'h2000, 3, F_CORRUPT, 3, -1, 0, 1'b0);
    run_copy(32'h1000, 32'h2000, 3, F_BADSRC, 1, -1, 0, 1'b0);
    reset_mid_copy();
    random_copies(24);

    chk("exp_a_drained", 128'(exp_a.size()), 128'(0));
    chk("exp_d_drained", 128'(exp_d.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
